// File: rtl/instr_disasm_stream_pkg.sv
// Shared definitions: RV32I opcodes, FSM states, mnemonic and ABI register-name tables.
package instr_disasm_stream_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // First character sits in the most significant byte.
  localparam logic [55:0] UNKNOWN_TEXT = "UNKNOWN";

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_STREAM} state_t;

  // ABI register name, 4 characters, left-justified and space-padded.
  function automatic logic [31:0] reg_name(input logic [4:0] idx);
    logic [31:0] n;
    n = "ZERO";
    case (idx)
      5'd0:  n = "ZERO";
      5'd1:  n = "RA  ";
      5'd2:  n = "SP  ";
      5'd3:  n = "GP  ";
      5'd4:  n = "TP  ";
      5'd5:  n = "T0  ";
      5'd6:  n = "T1  ";
      5'd7:  n = "T2  ";
      5'd8:  n = "S0  ";
      5'd9:  n = "S1  ";
      5'd10: n = "A0  ";
      5'd11: n = "A1  ";
      5'd12: n = "A2  ";
      5'd13: n = "A3  ";
      5'd14: n = "A4  ";
      5'd15: n = "A5  ";
      5'd16: n = "A6  ";
      5'd17: n = "A7  ";
      5'd18: n = "S2  ";
      5'd19: n = "S3  ";
      5'd20: n = "S4  ";
      5'd21: n = "S5  ";
      5'd22: n = "S6  ";
      5'd23: n = "S7  ";
      5'd24: n = "S8  ";
      5'd25: n = "S9  ";
      5'd26: n = "S10 ";
      5'd27: n = "S11 ";
      5'd28: n = "T3  ";
      5'd29: n = "T4  ";
      5'd30: n = "T5  ";
      5'd31: n = "T6  ";
      default: n = "ZERO";
    endcase
    return n;
  endfunction

  // Six-character mnemonic; all-zero means the encoding is not recognised.
  function automatic logic [47:0] mnemonic(input logic [6:0] opcode,
                                           input logic [2:0] funct3,
                                           input logic       alt);
    logic [47:0] m;
    m = '0;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          3'd0: m = alt ? "SUB   " : "ADD   ";
          3'd1: m = "SLL   ";
          3'd2: m = "SLT   ";
          3'd3: m = "SLTU  ";
          3'd4: m = "XOR   ";
          3'd5: m = alt ? "SRA   " : "SRL   ";
          3'd6: m = "OR    ";
          default: m = "AND   ";
        endcase
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'd0: m = "ADDI  ";
          3'd1: m = "SLLI  ";
          3'd2: m = "SLTI  ";
          3'd3: m = "SLTIU ";
          3'd4: m = "XORI  ";
          3'd5: m = alt ? "SRAI  " : "SRLI  ";
          3'd6: m = "ORI   ";
          default: m = "ANDI  ";
        endcase
      end
      OPC_LOAD: begin
        case (funct3)
          3'd0: m = "LB    ";
          3'd1: m = "LH    ";
          3'd2: m = "LW    ";
          3'd4: m = "LBU   ";
          3'd5: m = "LHU   ";
          default: m = '0;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'd0: m = "SB    ";
          3'd1: m = "SH    ";
          3'd2: m = "SW    ";
          default: m = '0;
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          3'd0: m = "BEQ   ";
          3'd1: m = "BNE   ";
          3'd4: m = "BLT   ";
          3'd5: m = "BGE   ";
          3'd6: m = "BLTU  ";
          3'd7: m = "BGEU  ";
          default: m = '0;
        endcase
      end
      OPC_JALR:  m = "JALR  ";
      OPC_JAL:   m = "JAL   ";
      OPC_LUI:   m = "LUI   ";
      OPC_AUIPC: m = "AUIPC ";
      default:   m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/instr_disasm_stream_fmt.sv
// Combinational line formatter: one instruction word -> fixed-width ASCII line,
// column c in bits [8c+7:8c].
module disasm_line_fmt #(
  parameter int LINE_CHARS = 24
) (
  input  logic [31:0]              instr,
  output logic [LINE_CHARS*8-1:0]  line
);
  import instr_disasm_stream_pkg::*;

  logic [47:0]  mn;
  logic [95:0]  names;     // operand names in print order, operand 0 in [31:0]
  logic [1:0]   num_ops;
  logic [127:0] ops;       // packed operand text, character i in [8i+7:8i]
  logic [3:0]   pos;
  logic         unused_imm;

  assign mn = mnemonic(instr[6:0], instr[14:12], instr[30]);
  assign unused_imm = ^{instr[31], instr[29:25]};

  // Choose which register fields are printed, and in what order, per opcode class.
  always_comb begin
    names   = {reg_name(instr[24:20]), reg_name(instr[19:15]), reg_name(instr[11:7])};
    num_ops = 2'd0;
    case (instr[6:0])
      OPC_OP:     num_ops = 2'd3;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: num_ops = 2'd2;
      OPC_STORE: begin
        names   = {32'h20202020, reg_name(instr[19:15]), reg_name(instr[24:20])};
        num_ops = 2'd2;
      end
      OPC_BRANCH: begin
        names   = {32'h20202020, reg_name(instr[24:20]), reg_name(instr[19:15])};
        num_ops = 2'd2;
      end
      OPC_JAL, OPC_LUI, OPC_AUIPC: num_ops = 2'd1;
      default: num_ops = 2'd0;
    endcase
    if (mn == '0) num_ops = 2'd0;
  end

  // Pack the operand names with commas, dropping the pad spaces of each name.
  always_comb begin
    ops = {16{8'h20}};
    pos = 4'd0;
    for (int k = 0; k < 3; k++) begin
      if (k < int'(num_ops)) begin
        if (k > 0) begin
          ops[{pos, 3'b000} +: 8] = 8'h2C;
          pos = pos + 4'd1;
        end
        for (int j = 0; j < 4; j++) begin
          if (names[32*k + 31 - 8*j -: 8] != 8'h20) begin
            ops[{pos, 3'b000} +: 8] = names[32*k + 31 - 8*j -: 8];
            pos = pos + 4'd1;
          end
        end
      end
    end
  end

  // Assemble the final line: mnemonic, gap column, operands, space fill.
  always_comb begin
    line = {LINE_CHARS{8'h20}};
    if (mn == '0) begin
      for (int i = 0; i < 7; i++) line[8*i +: 8] = UNKNOWN_TEXT[55 - 8*i -: 8];
    end else begin
      for (int i = 0; i < 6; i++) line[8*i +: 8] = mn[47 - 8*i -: 8];
      for (int i = 0; i < 14; i++) line[8*(7 + i) +: 8] = ops[8*i +: 8];
    end
  end

endmodule

// File: rtl/instr_disasm_stream.sv
// Snapshot NUM_CH instruction words, format each as an ASCII line and stream
// the lines one character per handshake, channel 0 first.
module instr_disasm_stream #(
  parameter int NUM_CH     = 5,
  parameter int LINE_CHARS = 24,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int COL_W      = $clog2(LINE_CHARS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 snap,
  input  logic [NUM_CH*32-1:0] instr_bus,
  output logic                 busy,
  output logic                 char_valid,
  input  logic                 char_ready,
  output logic [7:0]           char_data,
  output logic [COL_W-1:0]     char_col,
  output logic [CH_W-1:0]      ch_id,
  output logic                 line_done,
  output logic                 overrun
);
  import instr_disasm_stream_pkg::*;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_CHARS - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  state_t                  state_reg;
  logic [31:0]             words_reg [NUM_CH];
  logic [NUM_CH*32-1:0]    words_flat;
  logic [LINE_CHARS*8-1:0] line_reg;
  logic [LINE_CHARS*8-1:0] fmt_line;
  logic [31:0]             sel_word;
  logic [COL_W-1:0]        next_col;
  logic                    capture;

  assign capture  = (state_reg == ST_IDLE) && snap;
  assign sel_word = words_flat[{ch_id, 5'b00000} +: 32];
  assign next_col = char_col + 1'b1;

  // Last-column acceptance closes the line in the same cycle as the handshake.
  assign line_done = (state_reg == ST_STREAM) && char_valid && char_ready && (char_col == LAST_COL);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_snap
      // Capture this channel's word when a snap is accepted.
      always_ff @(posedge clk) begin
        if (reset) begin
          words_reg[gi] <= '0;
        end else if (capture) begin
          words_reg[gi] <= instr_bus[32*gi +: 32];
        end
      end
      assign words_flat[32*gi +: 32] = words_reg[gi];
    end
  endgenerate

  disasm_line_fmt #(.LINE_CHARS(LINE_CHARS)) u_fmt (
    .instr (sel_word),
    .line  (fmt_line)
  );

  // Sequencer: capture, load one line per channel, step columns on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      busy       <= 1'b0;
      char_valid <= 1'b0;
      char_data  <= 8'h20;
      char_col   <= '0;
      ch_id      <= '0;
      overrun    <= 1'b0;
      line_reg   <= {LINE_CHARS{8'h20}};
    end else begin
      if (snap && (state_reg != ST_IDLE)) overrun <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (snap) begin
            state_reg <= ST_DECODE;
            busy      <= 1'b1;
            ch_id     <= '0;
          end
        end
        ST_DECODE: begin
          line_reg   <= fmt_line;
          char_data  <= fmt_line[7:0];
          char_col   <= '0;
          char_valid <= 1'b1;
          state_reg  <= ST_STREAM;
        end
        ST_STREAM: begin
          if (char_valid && char_ready) begin
            if (char_col != LAST_COL) begin
              char_col  <= next_col;
              char_data <= line_reg[{next_col, 3'b000} +: 8];
            end else begin
              char_valid <= 1'b0;
              if (ch_id != LAST_CH) begin
                ch_id     <= ch_id + 1'b1;
                state_reg <= ST_DECODE;
              end else begin
                busy      <= 1'b0;
                state_reg <= ST_IDLE;
              end
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_disasm_stream.sv
// Scoreboard bench: expected characters are queued per snap from a string-level
// model; a negedge monitor pops one entry per accepted character.
module tb_instr_disasm_stream;
  localparam int NUM_CH     = 2;
  localparam int LINE_CHARS = 24;
  localparam int CH_W       = 1;
  localparam int COL_W      = 5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 snap = 1'b0;
  logic                 char_ready = 1'b0;
  logic [NUM_CH*32-1:0] instr_bus = '0;
  logic                 busy, char_valid, line_done, overrun;
  logic [7:0]           char_data;
  logic [COL_W-1:0]     char_col;
  logic [CH_W-1:0]      ch_id;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         ch;
    int         col;
    logic [7:0] c;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  string abi [32] = '{"ZERO","RA","SP","GP","TP","T0","T1","T2","S0","S1",
                      "A0","A1","A2","A3","A4","A5","A6","A7",
                      "S2","S3","S4","S5","S6","S7","S8","S9","S10","S11",
                      "T3","T4","T5","T6"};
  string r_mn  [8] = '{"ADD","SLL","SLT","SLTU","XOR","SRL","OR","AND"};
  string i_mn  [8] = '{"ADDI","SLLI","SLTI","SLTIU","XORI","SRLI","ORI","ANDI"};
  string ld_mn [8] = '{"LB","LH","LW","","LBU","LHU","",""};
  string st_mn [8] = '{"SB","SH","SW","","","","",""};
  string br_mn [8] = '{"BEQ","BNE","","","BLT","BGE","BLTU","BGEU"};
  logic [6:0] opc_list [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};

  instr_disasm_stream #(.NUM_CH(NUM_CH), .LINE_CHARS(LINE_CHARS)) dut (
    .clk        (clk),
    .reset      (reset),
    .snap       (snap),
    .instr_bus  (instr_bus),
    .busy       (busy),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_data  (char_data),
    .char_col   (char_col),
    .ch_id      (ch_id),
    .line_done  (line_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Expected text for one word, built as a string from the disassembly rules.
  function automatic string model_line(logic [31:0] w);
    string mn, ops, s, rd, rs1, rs2;
    int f3;
    f3  = int'(w[14:12]);
    rd  = abi[w[11:7]];
    rs1 = abi[w[19:15]];
    rs2 = abi[w[24:20]];
    mn  = "";
    ops = "";
    case (w[6:0])
      7'h33: begin
        mn = r_mn[f3];
        if (w[30] && f3 == 0) mn = "SUB";
        if (w[30] && f3 == 5) mn = "SRA";
        ops = {rd, ",", rs1, ",", rs2};
      end
      7'h13: begin
        mn = i_mn[f3];
        if (w[30] && f3 == 5) mn = "SRAI";
        ops = {rd, ",", rs1};
      end
      7'h03: begin mn = ld_mn[f3]; ops = {rd, ",", rs1}; end
      7'h67: begin mn = "JALR"; ops = {rd, ",", rs1}; end
      7'h23: begin mn = st_mn[f3]; ops = {rs2, ",", rs1}; end
      7'h63: begin mn = br_mn[f3]; ops = {rs1, ",", rs2}; end
      7'h6F: begin mn = "JAL"; ops = rd; end
      7'h37: begin mn = "LUI"; ops = rd; end
      7'h17: begin mn = "AUIPC"; ops = rd; end
      default: mn = "";
    endcase
    if (mn.len() == 0) begin
      s = "UNKNOWN";
    end else begin
      s = mn;
      while (s.len() < 7) s = {s, " "};
      s = {s, ops};
    end
    while (s.len() < LINE_CHARS) s = {s, " "};
    return s;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = opc_list[$urandom_range(0, 8)];
    return w;
  endfunction

  task automatic push_words(input logic [NUM_CH*32-1:0] bus);
    string s;
    exp_t  e;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      s = model_line(bus[32*ch +: 32]);
      for (int col = 0; col < LINE_CHARS; col++) begin
        e.ch   = ch;
        e.col  = col;
        e.c    = s[col];
        e.last = (col == LINE_CHARS - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per accepted character, plus hold checks under backpressure.
  initial begin : monitor
    exp_t             e;
    logic [7:0]       pd;
    logic [COL_W-1:0] pc;
    logic [CH_W-1:0]  pch;
    bit               stall;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (char_valid !== 1'b1 || char_data !== pd || char_col !== pc || ch_id !== pch) begin
            failures++;
            $display("FAIL hold: got valid=%0b data=%02h col=%0d ch=%0d expected valid=1 data=%02h col=%0d ch=%0d",
                     char_valid, char_data, char_col, ch_id, pd, pc, pch);
          end
        end
        stall = char_valid && !char_ready;
        pd = char_data;
        pc = char_col;
        pch = ch_id;
        if (char_valid && char_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_char: got data=%02h col=%0d ch=%0d expected no character", char_data, char_col, ch_id);
          end else begin
            e = exp_q.pop_front();
            if (char_data !== e.c || int'(char_col) != e.col || int'(ch_id) != e.ch || line_done !== e.last) begin
              failures++;
              $display("FAIL char: got data=%02h col=%0d ch=%0d done=%0b expected data=%02h col=%0d ch=%0d done=%0b",
                       char_data, char_col, ch_id, line_done, e.c, e.col, e.ch, e.last);
            end
          end
        end else begin
          checks++;
          if (line_done !== 1'b0) begin
            failures++;
            $display("FAIL stray_line_done: got %0b expected 0", line_done);
          end
        end
      end
    end
  end

  // One snapshot and its stream. mode 0: always ready, 1: random ready,
  // 2: ready held low 3 cycles at col 5. ov_col/rst_col < 0 disable those events.
  task automatic run_stream(input logic [NUM_CH*32-1:0] bus, input int mode,
                            input int ov_col, input int rst_col);
    int hold;
    bit ov_done, gap, fin, done_flag;
    hold = 0;
    ov_done = 1'b0;
    done_flag = 1'b0;
    instr_bus = bus;
    push_words(bus);
    snap = 1'b1;
    char_ready = 1'b1;
    @(posedge clk); #1;
    snap = 1'b0;
    chk("busy_after_snap", {31'd0, busy}, 32'd1);
    chk("valid_in_decode", {31'd0, char_valid}, 32'd0);
    @(posedge clk); #1;
    chk("valid_latency", {31'd0, char_valid}, 32'd1);
    chk("first_col", 32'(char_col), 32'd0);
    chk("first_ch", 32'(ch_id), 32'd0);
    for (int cyc = 0; cyc < 400 && !done_flag; cyc++) begin
      case (mode)
        0: char_ready = 1'b1;
        1: char_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (char_valid && int'(ch_id) == 0 && int'(char_col) == 5 && hold < 3) begin
            char_ready = 1'b0;
            hold++;
          end else begin
            char_ready = 1'b1;
          end
        end
      endcase
      snap = 1'b0;
      if (ov_col >= 0 && !ov_done && char_valid && int'(char_col) == ov_col) begin
        snap = 1'b1;
        ov_done = 1'b1;
      end
      if (rst_col >= 0 && char_valid && int'(char_col) == rst_col) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        chk("reset_valid", {31'd0, char_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        chk("reset_line_done", {31'd0, line_done}, 32'd0);
        done_flag = 1'b1;
      end else begin
        gap = char_valid && char_ready && int'(char_col) == LINE_CHARS - 1 && int'(ch_id) != NUM_CH - 1;
        fin = char_valid && char_ready && int'(char_col) == LINE_CHARS - 1 && int'(ch_id) == NUM_CH - 1;
        @(posedge clk); #1;
        snap = 1'b0;
        if (gap) chk("decode_gap_valid", {31'd0, char_valid}, 32'd0);
        if (fin) begin
          chk("busy_fall", {31'd0, busy}, 32'd0);
          chk("valid_fall", {31'd0, char_valid}, 32'd0);
          done_flag = 1'b1;
        end
      end
    end
    snap = 1'b0;
    if (!done_flag) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout: got busy=%0b after 400 cycles expected stream end", busy);
    end
  endtask

  initial begin : stimulus
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, char_valid}, 32'd0);
    chk("rst_data", {24'd0, char_data}, 32'h20);
    chk("rst_col", 32'(char_col), 32'd0);
    chk("rst_ch", 32'(ch_id), 32'd0);
    chk("rst_line_done", {31'd0, line_done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_stream({32'h40B50533, 32'h003100B3}, 0, -1, -1);
    run_stream({32'hFFFFFFFF, 32'h00512423}, 0, -1, -1);
    run_stream({32'h0000006F, 32'h00000013}, 2, -1, -1);
    chk("overrun_clear", {31'd0, overrun}, 32'd0);
    run_stream({rand_word(), rand_word()}, 0, 10, -1);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    run_stream({rand_word(), rand_word()}, 1, -1, 12);
    for (int n = 0; n < 20; n++) begin
      run_stream({rand_word(), rand_word()}, 1, -1, -1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
